axi_mem_responder: RTL and testbench
====================================

AXI_MEM_RESPONDER -- requirements
Module: axi_mem_responder

Interface
REQ-001 SHALL have parameter AXI_ID_W, default 1 (minimum 1), width of all ID fields.
REQ-002 SHALL have parameter AXI_ADDR_W, default 32, byte-address width.
REQ-003 SHALL have parameter AXI_DATA_W, default 32, data width; only 32 is supported.
REQ-004 SHALL have parameter MEM_ADDR_W, default 12, log2 of the number of 32-bit words stored.
REQ-005 SHALL have the following ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- axi_awid/awaddr/awlen/awsize/awburst  in  AXI_ID_W/AXI_ADDR_W/8/3/2  write address.
- axi_awvalid in 1; axi_awready out 1.
- axi_wdata/wstrb/wlast  in  32/4/1  write data; axi_wvalid in 1; axi_wready out 1.
- axi_bid/bresp  out  AXI_ID_W/2  write response; axi_bvalid out 1; axi_bready in 1.
- axi_arid/araddr/arlen/arsize/arburst  in  AXI_ID_W/AXI_ADDR_W/8/3/2  read address.
- axi_arvalid in 1; axi_arready out 1.
- axi_rid/rdata/rresp/rlast  out  AXI_ID_W/32/2/1  read data; axi_rvalid out 1; axi_rready in 1.

Function
REQ-006 SHALL act as an AXI4 slave backed by an internal 2^MEM_ADDR_W x 32 RAM with a synchronous read port and byte-enabled writes.
REQ-007 SHALL process one transaction at a time using FSM states IDLE, WRITE, WRESP and READ.
REQ-008 SHALL, in IDLE, assert awready or arready (never both) combinationally on the corresponding valid; on the handshake it SHALL latch ID, word address araddr[MEM_ADDR_W+1:2], len, size and burst.
REQ-009 SHALL arbitrate simultaneous awvalid and arvalid in IDLE round-robin: grant the type not served last; after reset, write wins.
REQ-010 SHALL go IDLE->WRITE on the AW handshake and assert wready=1 continuously in WRITE.
REQ-011 SHALL, on each W handshake, write the bytes enabled by wstrb at the current word address, then advance the beat counter.
REQ-012 SHALL increment the word address by 1 per beat for burst INCR, WRAP and reserved; it SHALL hold the address for FIXED; it SHALL wrap modulo 2^MEM_ADDR_W.
REQ-013 SHALL go WRITE->WRESP after beat awlen+1; in WRESP it SHALL assert bvalid with bid equal to the latched ID, and return to IDLE on bready.
REQ-014 SHALL set bresp=SLVERR(2'b10) if awsize!=2, in which case no RAM bytes are written; it SHALL also set SLVERR if wlast disagrees with the beat count on any beat. Otherwise bresp=OKAY(2'b00).
REQ-015 SHALL go IDLE->READ on the AR handshake, present araddr's word to the RAM in the same cycle, and assert rvalid on the next cycle (1-cycle latency).
REQ-016 SHALL sustain one R beat per cycle while rready=1; rdata/rresp/rlast SHALL remain stable while rvalid=1 and rready=0.
REQ-017 SHALL assert rlast on beat arlen+1 and return to IDLE on its handshake; rid SHALL equal the latched ID throughout.
REQ-018 SHALL, if arsize!=2, return rresp=SLVERR and rdata=0 on every beat, with beat count unchanged.
REQ-019 SHALL never issue a W handshake outside WRITE; wvalid arriving before AW is accepted waits with wready=0.
REQ-020 SHALL apply REQ-012 address arithmetic to reads; an 8-bit len gives bursts of up to 256 beats.

Reset
REQ-021 SHALL, on rst, immediately drive the FSM to IDLE and set awready, wready, bvalid, arready, rvalid and rlast to 0; bresp, rresp, bid, rid and rdata SHALL be 0.
REQ-022 SHALL abandon any transaction in progress on rst with no response issued; RAM contents are not cleared and RAM writes SHALL be suppressed while rst=1.
REQ-023 SHALL set the round-robin priority to write on reset.

Verification
REQ-024 Bench SHALL cover: AW addr 0x40, len 3, INCR, size 2, data 0x11..0x44, wstrb 0xF -> bresp OKAY; then AR addr 0x40, len 3 -> rdata 0x11,0x22,0x33,0x44 on 4 consecutive cycles, rlast on the 4th.
REQ-025 Bench SHALL cover: write 0xAABBCCDD to 0x0, then write 0x00000011 with wstrb 4'b0001 -> read of 0x0 returns 0xAABBCC11.
REQ-026 Bench SHALL cover: awvalid and arvalid high together in IDLE right after reset -> write granted first, read granted next; repeat the race -> read granted first.
REQ-027 Bench SHALL cover: MEM_ADDR_W=4, INCR read len 1 at word 15 -> data from words 15 then 0; FIXED write len 2 to word 3 -> only word 3 changes, holding the last beat's data.
REQ-028 Bench SHALL cover: arsize=1, len 1 -> two beats with rresp=2'b10 and rdata=0; wlast asserted on beat 1 of a len-2 write -> bresp=2'b10 after 3 beats.
REQ-029 Bench SHALL cover: rready held low for 5 cycles mid-burst -> rdata stable; rst asserted mid-write -> outputs 0 next edge, FSM in IDLE, a fresh transaction completes correctly.

Source files
------------

// File: rtl/axi_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : axi_mem_responder
//  Purpose  : AXI4 slave backed by an internal 2^MEM_ADDR_W x 32 RAM.
//             Serves one transaction at a time (IDLE/WRITE/WRESP/READ).
//             Read port is synchronous: one cycle from address to data.
//             Simultaneous AW/AR requests are granted round-robin.
//  Ports    : clk, rst (async, active-high)
//             AW channel : axi_aw{id,addr,len,size,burst,valid,ready}
//             W channel  : axi_w{data,strb,last,valid,ready}
//             B channel  : axi_b{id,resp,valid,ready}
//             AR channel : axi_ar{id,addr,len,size,burst,valid,ready}
//             R channel  : axi_r{id,data,resp,last,valid,ready}
//  Revision : 1.0 - initial release
// ============================================================================
module axi_mem_responder #(
    parameter int AXI_ID_W   = 1,
    parameter int AXI_ADDR_W = 32,
    parameter int AXI_DATA_W = 32,
    parameter int MEM_ADDR_W = 12
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [AXI_ID_W-1:0]     axi_awid,
    input  logic [AXI_ADDR_W-1:0]   axi_awaddr,
    input  logic [7:0]              axi_awlen,
    input  logic [2:0]              axi_awsize,
    input  logic [1:0]              axi_awburst,
    input  logic                    axi_awvalid,
    output logic                    axi_awready,
    input  logic [AXI_DATA_W-1:0]   axi_wdata,
    input  logic [AXI_DATA_W/8-1:0] axi_wstrb,
    input  logic                    axi_wlast,
    input  logic                    axi_wvalid,
    output logic                    axi_wready,
    output logic [AXI_ID_W-1:0]     axi_bid,
    output logic [1:0]              axi_bresp,
    output logic                    axi_bvalid,
    input  logic                    axi_bready,
    input  logic [AXI_ID_W-1:0]     axi_arid,
    input  logic [AXI_ADDR_W-1:0]   axi_araddr,
    input  logic [7:0]              axi_arlen,
    input  logic [2:0]              axi_arsize,
    input  logic [1:0]              axi_arburst,
    input  logic                    axi_arvalid,
    output logic                    axi_arready,
    output logic [AXI_ID_W-1:0]     axi_rid,
    output logic [AXI_DATA_W-1:0]   axi_rdata,
    output logic [1:0]              axi_rresp,
    output logic                    axi_rlast,
    output logic                    axi_rvalid,
    input  logic                    axi_rready
);

    localparam logic [1:0] c_RESP_OKAY   = 2'b00;
    localparam logic [1:0] c_RESP_SLVERR = 2'b10;
    localparam logic [1:0] c_BURST_FIXED = 2'b00;
    localparam logic [2:0] c_SIZE_WORD   = 3'd2;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_WRESP = 2'd2,
        S_READ  = 2'd3
    } state_t;

    state_t                  r_state;
    logic [MEM_ADDR_W-1:0]   r_addr;
    logic [7:0]              r_len;
    logic [7:0]              r_cnt;
    logic [1:0]              r_burst;
    logic [AXI_ID_W-1:0]     r_id;
    logic                    r_size_err;
    logic                    r_last_err;
    logic                    r_prio_w;      // 1: write wins a tie
    logic [AXI_DATA_W-1:0]   r_rdata;
    logic [1:0]              r_rresp;
    logic                    r_rvalid;
    logic                    r_rlast;
    logic [AXI_DATA_W-1:0]   r_mem [0:(1<<MEM_ADDR_W)-1];

    logic                    w_idle;
    logic                    w_grant_w;
    logic                    w_aw_hs;
    logic                    w_ar_hs;
    logic                    w_w_hs;
    logic                    w_r_hs;
    logic                    w_last_beat;
    logic                    w_ar_size_err;
    logic                    w_mem_we;
    logic [MEM_ADDR_W-1:0]   w_next_addr;
    logic [MEM_ADDR_W-1:0]   w_aw_word;
    logic [MEM_ADDR_W-1:0]   w_ar_word;
    logic                    w_unused_addr;

    // Ready outputs are combinational; rst gating keeps them low during reset
    // even while a master holds valid.
    assign w_idle      = (r_state == S_IDLE) && !rst;
    assign w_grant_w   = axi_awvalid && (!axi_arvalid || r_prio_w);
    assign w_aw_hs     = w_idle && w_grant_w;
    assign w_ar_hs     = w_idle && axi_arvalid && !w_grant_w;
    assign w_w_hs      = (r_state == S_WRITE) && axi_wvalid;
    assign w_r_hs      = r_rvalid && axi_rready;
    assign w_last_beat = (r_cnt == r_len);
    assign w_aw_word   = axi_awaddr[MEM_ADDR_W+1:2];
    assign w_ar_word   = axi_araddr[MEM_ADDR_W+1:2];
    assign w_ar_size_err = (axi_arsize != c_SIZE_WORD);
    // FIXED holds the address; every other burst code steps by one word and
    // wraps naturally at the memory size.
    assign w_next_addr = (r_burst == c_BURST_FIXED) ? r_addr
                                                    : r_addr + MEM_ADDR_W'(1);
    assign w_mem_we    = w_w_hs && !r_size_err && !rst;
    assign w_unused_addr = ^{axi_awaddr, axi_araddr};

    assign axi_awready = w_aw_hs;
    assign axi_arready = w_ar_hs;
    assign axi_wready  = (r_state == S_WRITE);
    assign axi_bvalid  = (r_state == S_WRESP);
    assign axi_bresp   = ((r_state == S_WRESP) && (r_size_err || r_last_err))
                         ? c_RESP_SLVERR : c_RESP_OKAY;
    assign axi_bid     = r_id;
    assign axi_rid     = r_id;
    assign axi_rdata   = r_rdata;
    assign axi_rresp   = r_rresp;
    assign axi_rvalid  = r_rvalid;
    assign axi_rlast   = r_rlast;

    // RAM write port with byte enables; contents survive reset.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            for (int b = 0; b < AXI_DATA_W/8; b++) begin
                if (axi_wstrb[b]) begin
                    r_mem[r_addr][8*b +: 8] <= axi_wdata[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_addr     <= '0;
            r_len      <= '0;
            r_cnt      <= '0;
            r_burst    <= '0;
            r_id       <= '0;
            r_size_err <= 1'b0;
            r_last_err <= 1'b0;
            r_prio_w   <= 1'b1;
            r_rdata    <= '0;
            r_rresp    <= c_RESP_OKAY;
            r_rvalid   <= 1'b0;
            r_rlast    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_aw_hs) begin
                        r_id       <= axi_awid;
                        r_addr     <= w_aw_word;
                        r_len      <= axi_awlen;
                        r_burst    <= axi_awburst;
                        r_cnt      <= '0;
                        r_size_err <= (axi_awsize != c_SIZE_WORD);
                        r_last_err <= 1'b0;
                        r_prio_w   <= 1'b0;
                        r_state    <= S_WRITE;
                    end else if (w_ar_hs) begin
                        // Word address goes to the RAM now; data shows next cycle.
                        r_id       <= axi_arid;
                        r_addr     <= w_ar_word;
                        r_len      <= axi_arlen;
                        r_burst    <= axi_arburst;
                        r_cnt      <= '0;
                        r_size_err <= w_ar_size_err;
                        r_rdata    <= w_ar_size_err ? '0 : r_mem[w_ar_word];
                        r_rresp    <= w_ar_size_err ? c_RESP_SLVERR : c_RESP_OKAY;
                        r_rvalid   <= 1'b1;
                        r_rlast    <= (axi_arlen == 8'd0);
                        r_prio_w   <= 1'b1;
                        r_state    <= S_READ;
                    end
                end
                S_WRITE: begin
                    if (w_w_hs) begin
                        if (axi_wlast != w_last_beat) begin
                            r_last_err <= 1'b1;
                        end
                        r_addr <= w_next_addr;
                        r_cnt  <= r_cnt + 8'd1;
                        if (w_last_beat) begin
                            r_state <= S_WRESP;
                        end
                    end
                end
                S_WRESP: begin
                    if (axi_bready) begin
                        r_state <= S_IDLE;
                    end
                end
                S_READ: begin
                    // Without a handshake every R output holds its value.
                    if (w_r_hs) begin
                        if (r_rlast) begin
                            r_rvalid <= 1'b0;
                            r_rlast  <= 1'b0;
                            r_state  <= S_IDLE;
                        end else begin
                            r_addr  <= w_next_addr;
                            r_cnt   <= r_cnt + 8'd1;
                            r_rdata <= r_size_err ? '0 : r_mem[w_next_addr];
                            r_rlast <= ((r_cnt + 8'd1) == r_len);
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_axi_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_axi_mem_responder
//  Purpose  : Directed self-checking bench for axi_mem_responder, built with
//             a 16-word memory so address wrap is reachable.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_axi_mem_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  axi_awid = '0;
    logic [31:0] axi_awaddr = '0;
    logic [7:0]  axi_awlen = '0;
    logic [2:0]  axi_awsize = '0;
    logic [1:0]  axi_awburst = '0;
    logic        axi_awvalid = 1'b0;
    logic        axi_awready;
    logic [31:0] axi_wdata = '0;
    logic [3:0]  axi_wstrb = '0;
    logic        axi_wlast = 1'b0;
    logic        axi_wvalid = 1'b0;
    logic        axi_wready;
    logic [1:0]  axi_bid;
    logic [1:0]  axi_bresp;
    logic        axi_bvalid;
    logic        axi_bready = 1'b0;
    logic [1:0]  axi_arid = '0;
    logic [31:0] axi_araddr = '0;
    logic [7:0]  axi_arlen = '0;
    logic [2:0]  axi_arsize = '0;
    logic [1:0]  axi_arburst = '0;
    logic        axi_arvalid = 1'b0;
    logic        axi_arready;
    logic [1:0]  axi_rid;
    logic [31:0] axi_rdata;
    logic [1:0]  axi_rresp;
    logic        axi_rlast;
    logic        axi_rvalid;
    logic        axi_rready = 1'b0;

    int errors = 0;
    int checks = 0;

    logic [31:0] obs_d  [16];
    logic        obs_l  [16];
    logic [1:0]  obs_r  [16];
    logic [1:0]  obs_id [16];
    int          rd_first_wait;
    int          rd_gaps;
    logic [1:0]  b_resp;
    logic [1:0]  b_id;

    axi_mem_responder #(
        .AXI_ID_W   (2),
        .AXI_ADDR_W (32),
        .AXI_DATA_W (32),
        .MEM_ADDR_W (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .axi_awid    (axi_awid),
        .axi_awaddr  (axi_awaddr),
        .axi_awlen   (axi_awlen),
        .axi_awsize  (axi_awsize),
        .axi_awburst (axi_awburst),
        .axi_awvalid (axi_awvalid),
        .axi_awready (axi_awready),
        .axi_wdata   (axi_wdata),
        .axi_wstrb   (axi_wstrb),
        .axi_wlast   (axi_wlast),
        .axi_wvalid  (axi_wvalid),
        .axi_wready  (axi_wready),
        .axi_bid     (axi_bid),
        .axi_bresp   (axi_bresp),
        .axi_bvalid  (axi_bvalid),
        .axi_bready  (axi_bready),
        .axi_arid    (axi_arid),
        .axi_araddr  (axi_araddr),
        .axi_arlen   (axi_arlen),
        .axi_arsize  (axi_arsize),
        .axi_arburst (axi_arburst),
        .axi_arvalid (axi_arvalid),
        .axi_arready (axi_arready),
        .axi_rid     (axi_rid),
        .axi_rdata   (axi_rdata),
        .axi_rresp   (axi_rresp),
        .axi_rlast   (axi_rlast),
        .axi_rvalid  (axi_rvalid),
        .axi_rready  (axi_rready)
    );

    always #5 clk = ~clk;

    // ---------------- channel drivers (inputs change at posedge+1) ----------
    task automatic aw_send(input logic [1:0] id, input logic [31:0] addr,
                           input logic [7:0] len, input logic [2:0] size,
                           input logic [1:0] burst);
        bit ok = 0;
        axi_awid = id; axi_awaddr = addr; axi_awlen = len;
        axi_awsize = size; axi_awburst = burst; axi_awvalid = 1'b1;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (axi_awready) ok = 1;
            @(posedge clk);
        end
        #1 axi_awvalid = 1'b0;
        checks++;
        if (!ok) begin errors++; $display("FAIL aw_handshake: awready=0 after 50 cycles, required 1"); end
    endtask

    task automatic ar_send(input logic [1:0] id, input logic [31:0] addr,
                           input logic [7:0] len, input logic [2:0] size,
                           input logic [1:0] burst);
        bit ok = 0;
        axi_arid = id; axi_araddr = addr; axi_arlen = len;
        axi_arsize = size; axi_arburst = burst; axi_arvalid = 1'b1;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (axi_arready) ok = 1;
            @(posedge clk);
        end
        #1 axi_arvalid = 1'b0;
        checks++;
        if (!ok) begin errors++; $display("FAIL ar_handshake: arready=0 after 50 cycles, required 1"); end
    endtask

    task automatic w_send(input logic [31:0] data, input logic [3:0] strb, input logic last);
        bit ok = 0;
        axi_wdata = data; axi_wstrb = strb; axi_wlast = last; axi_wvalid = 1'b1;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (axi_wready) ok = 1;
            @(posedge clk);
        end
        #1 axi_wvalid = 1'b0;
        checks++;
        if (!ok) begin errors++; $display("FAIL w_handshake: wready=0 after 50 cycles, required 1"); end
    endtask

    task automatic b_recv();
        bit ok = 0;
        axi_bready = 1'b1;
        b_resp = 2'bxx; b_id = 2'bxx;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (axi_bvalid) begin ok = 1; b_resp = axi_bresp; b_id = axi_bid; end
            @(posedge clk);
        end
        #1 axi_bready = 1'b0;
        checks++;
        if (!ok) begin errors++; $display("FAIL b_handshake: bvalid=0 after 50 cycles, required 1"); end
    endtask

    // Records n R beats with rready held high; rd_first_wait/rd_gaps count
    // idle cycles before the first beat and between beats.
    task automatic rd_collect(input int n);
        int w;
        rd_gaps = 0; rd_first_wait = 0;
        axi_rready = 1'b1;
        for (int i = 0; i < n; i++) begin
            w = 0;
            @(negedge clk);
            while (!axi_rvalid && w < 20) begin w++; @(negedge clk); end
            if (i == 0) rd_first_wait = w; else rd_gaps += w;
            obs_d[i] = axi_rdata; obs_l[i] = axi_rlast;
            obs_r[i] = axi_rresp; obs_id[i] = axi_rid;
            @(posedge clk);
            #1;
        end
        axi_rready = 1'b0;
    endtask

    // ---------------- scenarios ---------------------------------------------
    task automatic test_reset();
        axi_wvalid = 1'b1;
        @(negedge clk);
        checks++;
        if ({axi_awready, axi_wready, axi_bvalid, axi_arready, axi_rvalid, axi_rlast} !== 6'b0) begin
            errors++; $display("FAIL reset_ctrl: got %b required 000000",
                {axi_awready, axi_wready, axi_bvalid, axi_arready, axi_rvalid, axi_rlast});
        end
        checks++;
        if ({axi_bresp, axi_rresp, axi_bid, axi_rid} !== 8'h00 || axi_rdata !== 32'h0) begin
            errors++; $display("FAIL reset_data: got resp/id %h rdata %h required 00/0",
                {axi_bresp, axi_rresp, axi_bid, axi_rid}, axi_rdata);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (axi_wready !== 1'b0) begin
            errors++; $display("FAIL idle_wready: got %b required 0 with wvalid before AW", axi_wready);
        end
        axi_wvalid = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_race();
        axi_awid = 2'd1; axi_awaddr = 32'h10; axi_awlen = 8'd0; axi_awsize = 3'd2; axi_awburst = 2'd1;
        axi_arid = 2'd2; axi_araddr = 32'h10; axi_arlen = 8'd0; axi_arsize = 3'd2; axi_arburst = 2'd1;
        axi_awvalid = 1'b1; axi_arvalid = 1'b1;
        @(negedge clk);
        checks++;
        if ({axi_awready, axi_arready} !== 2'b10) begin
            errors++; $display("FAIL race1_grant: aw/ar ready %b required 10", {axi_awready, axi_arready});
        end
        @(posedge clk); #1 axi_awvalid = 1'b0;
        #2;
        checks++;
        if (axi_arready !== 1'b0) begin
            errors++; $display("FAIL race_busy_arready: got %b required 0 outside IDLE", axi_arready);
        end
        w_send(32'h5A5A0001, 4'hF, 1'b1);
        b_recv();
        checks++;
        if (b_resp !== 2'b00 || b_id !== 2'd1) begin
            errors++; $display("FAIL race_b: bresp %b bid %0d required 00 1", b_resp, b_id);
        end
        // Pending AR still high, new AW raised: last served was a write.
        axi_awid = 2'd3; axi_awaddr = 32'h14; axi_awvalid = 1'b1;
        @(negedge clk);
        checks++;
        if ({axi_awready, axi_arready} !== 2'b01) begin
            errors++; $display("FAIL race2_grant: aw/ar ready %b required 01", {axi_awready, axi_arready});
        end
        @(posedge clk); #1 axi_arvalid = 1'b0;
        rd_collect(1);
        checks++;
        if (obs_d[0] !== 32'h5A5A0001 || obs_id[0] !== 2'd2 || obs_l[0] !== 1'b1) begin
            errors++; $display("FAIL race_read: rdata %h rid %0d rlast %b required 5a5a0001 2 1",
                obs_d[0], obs_id[0], obs_l[0]);
        end
        @(negedge clk);
        checks++;
        if (axi_awready !== 1'b1) begin
            errors++; $display("FAIL race_aw_after_read: awready %b required 1", axi_awready);
        end
        @(posedge clk); #1 axi_awvalid = 1'b0;
        w_send(32'h5A5A0002, 4'hF, 1'b1);
        b_recv();
        checks++;
        if (b_resp !== 2'b00 || b_id !== 2'd3) begin
            errors++; $display("FAIL race_b2: bresp %b bid %0d required 00 3", b_resp, b_id);
        end
    endtask

    task automatic test_incr_burst();
        aw_send(2'd1, 32'h40, 8'd3, 3'd2, 2'd1);
        for (int i = 0; i < 4; i++) w_send(32'h11 * (i + 1), 4'hF, i == 3);
        b_recv();
        checks++;
        if (b_resp !== 2'b00 || b_id !== 2'd1) begin
            errors++; $display("FAIL incr_b: bresp %b bid %0d required 00 1", b_resp, b_id);
        end
        ar_send(2'd2, 32'h40, 8'd3, 3'd2, 2'd1);
        rd_collect(4);
        checks++;
        if (rd_first_wait != 0 || rd_gaps != 0) begin
            errors++; $display("FAIL incr_timing: first wait %0d gaps %0d required 0 0", rd_first_wait, rd_gaps);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (obs_d[i] !== 32'h11 * (i + 1) || obs_l[i] !== (i == 3) || obs_r[i] !== 2'b00 || obs_id[i] !== 2'd2) begin
                errors++; $display("FAIL incr_beat%0d: data %h last %b resp %b rid %0d required %h %b 00 2",
                    i, obs_d[i], obs_l[i], obs_r[i], obs_id[i], 32'h11 * (i + 1), i == 3);
            end
        end
    endtask

    task automatic test_strobe();
        aw_send(2'd0, 32'h0, 8'd0, 3'd2, 2'd1);
        w_send(32'hAABBCCDD, 4'hF, 1'b1);
        b_recv();
        aw_send(2'd0, 32'h0, 8'd0, 3'd2, 2'd1);
        w_send(32'h00000011, 4'b0001, 1'b1);
        b_recv();
        ar_send(2'd0, 32'h0, 8'd0, 3'd2, 2'd1);
        rd_collect(1);
        checks++;
        if (obs_d[0] !== 32'hAABBCC11 || obs_l[0] !== 1'b1) begin
            errors++; $display("FAIL strobe_merge: rdata %h rlast %b required aabbcc11 1", obs_d[0], obs_l[0]);
        end
    endtask

    task automatic test_wrap_fixed();
        aw_send(2'd0, 32'h3C, 8'd0, 3'd2, 2'd1);
        w_send(32'hF0F0000F, 4'hF, 1'b1);
        b_recv();
        aw_send(2'd0, 32'h00, 8'd0, 3'd2, 2'd1);
        w_send(32'h0000AAAA, 4'hF, 1'b1);
        b_recv();
        ar_send(2'd1, 32'h3C, 8'd1, 3'd2, 2'd1);
        rd_collect(2);
        checks++;
        if (obs_d[0] !== 32'hF0F0000F || obs_d[1] !== 32'h0000AAAA || obs_l[1] !== 1'b1) begin
            errors++; $display("FAIL wrap_read: data %h %h last %b required f0f0000f 0000aaaa 1",
                obs_d[0], obs_d[1], obs_l[1]);
        end
        aw_send(2'd0, 32'h08, 8'd2, 3'd2, 2'd1);
        w_send(32'h200, 4'hF, 1'b0); w_send(32'h300, 4'hF, 1'b0); w_send(32'h400, 4'hF, 1'b1);
        b_recv();
        aw_send(2'd0, 32'h0C, 8'd2, 3'd2, 2'd0);
        w_send(32'hA1, 4'hF, 1'b0); w_send(32'hB2, 4'hF, 1'b0); w_send(32'hC3, 4'hF, 1'b1);
        b_recv();
        checks++;
        if (b_resp !== 2'b00) begin
            errors++; $display("FAIL fixed_b: bresp %b required 00", b_resp);
        end
        ar_send(2'd0, 32'h08, 8'd2, 3'd2, 2'd1);
        rd_collect(3);
        checks++;
        if (obs_d[0] !== 32'h200 || obs_d[1] !== 32'hC3 || obs_d[2] !== 32'h400) begin
            errors++; $display("FAIL fixed_write: words2-4 %h %h %h required 200 c3 400",
                obs_d[0], obs_d[1], obs_d[2]);
        end
    endtask

    task automatic test_errors();
        ar_send(2'd1, 32'h08, 8'd1, 3'd1, 2'd1);
        rd_collect(2);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (obs_d[i] !== 32'h0 || obs_r[i] !== 2'b10 || obs_l[i] !== (i == 1)) begin
                errors++; $display("FAIL rsize_beat%0d: data %h resp %b last %b required 0 10 %b",
                    i, obs_d[i], obs_r[i], obs_l[i], i == 1);
            end
        end
        aw_send(2'd2, 32'h30, 8'd2, 3'd2, 2'd1);
        w_send(32'h1, 4'hF, 1'b1); w_send(32'h2, 4'hF, 1'b0); w_send(32'h3, 4'hF, 1'b1);
        b_recv();
        checks++;
        if (b_resp !== 2'b10 || b_id !== 2'd2) begin
            errors++; $display("FAIL wlast_err: bresp %b bid %0d required 10 2", b_resp, b_id);
        end
        aw_send(2'd0, 32'h08, 8'd0, 3'd1, 2'd1);
        w_send(32'hDEADBEEF, 4'hF, 1'b1);
        b_recv();
        checks++;
        if (b_resp !== 2'b10) begin
            errors++; $display("FAIL wsize_err: bresp %b required 10", b_resp);
        end
        ar_send(2'd0, 32'h08, 8'd0, 3'd2, 2'd1);
        rd_collect(1);
        checks++;
        if (obs_d[0] !== 32'h200) begin
            errors++; $display("FAIL wsize_nowrite: word2 %h required 200", obs_d[0]);
        end
    endtask

    task automatic test_stall();
        aw_send(2'd0, 32'h20, 8'd3, 3'd2, 2'd1);
        for (int i = 0; i < 4; i++) w_send(32'h80080000 + i, 4'hF, i == 3);
        b_recv();
        ar_send(2'd3, 32'h20, 8'd3, 3'd2, 2'd1);
        rd_collect(2);
        checks++;
        if (obs_d[0] !== 32'h80080000 || obs_d[1] !== 32'h80080001) begin
            errors++; $display("FAIL stall_pre: data %h %h required 80080000 80080001", obs_d[0], obs_d[1]);
        end
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++;
            if (axi_rvalid !== 1'b1 || axi_rdata !== 32'h80080002 || axi_rlast !== 1'b0 || axi_rresp !== 2'b00) begin
                errors++; $display("FAIL stall_hold%0d: valid %b data %h last %b required 1 80080002 0",
                    c, axi_rvalid, axi_rdata, axi_rlast);
            end
            @(posedge clk); #1;
        end
        rd_collect(2);
        checks++;
        if (obs_d[0] !== 32'h80080002 || obs_d[1] !== 32'h80080003 || obs_l[0] !== 1'b0 || obs_l[1] !== 1'b1) begin
            errors++; $display("FAIL stall_post: data %h %h last %b%b required 80080002 80080003 01",
                obs_d[0], obs_d[1], obs_l[0], obs_l[1]);
        end
    endtask

    task automatic test_reset_mid();
        aw_send(2'd1, 32'h30, 8'd2, 3'd2, 2'd1);
        w_send(32'h12340001, 4'hF, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if ({axi_wready, axi_bvalid, axi_awready, axi_rvalid} !== 4'b0) begin
            errors++; $display("FAIL rst_mid_async: wready/bvalid/awready/rvalid %b required 0000",
                {axi_wready, axi_bvalid, axi_awready, axi_rvalid});
        end
        @(posedge clk); #1;
        checks++;
        if (axi_wready !== 1'b0 || axi_bid !== 2'd0) begin
            errors++; $display("FAIL rst_mid_edge: wready %b bid %0d required 0 0", axi_wready, axi_bid);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        aw_send(2'd3, 32'h34, 8'd0, 3'd2, 2'd1);
        w_send(32'h13130013, 4'hF, 1'b1);
        b_recv();
        checks++;
        if (b_resp !== 2'b00 || b_id !== 2'd3) begin
            errors++; $display("FAIL rst_fresh_b: bresp %b bid %0d required 00 3", b_resp, b_id);
        end
        ar_send(2'd1, 32'h30, 8'd1, 3'd2, 2'd1);
        rd_collect(2);
        checks++;
        if (obs_d[0] !== 32'h12340001 || obs_d[1] !== 32'h13130013 || obs_l[1] !== 1'b1) begin
            errors++; $display("FAIL rst_fresh_read: data %h %h last %b required 12340001 13130013 1",
                obs_d[0], obs_d[1], obs_l[1]);
        end
    endtask

    initial begin
        test_reset();
        test_race();
        test_incr_burst();
        test_strobe();
        test_wrap_fixed();
        test_errors();
        test_stall();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
